// File: rtl/xsdddr_pkg.sv
// Shared definitions for the xsdddr_bus pad front end: direction FSM
// encoding, capture pipeline depths and the park-counter width helper.
package xsdddr_pkg;

  typedef enum logic [1:0] {
    S_IN   = 2'd0,
    S_OUT  = 2'd1,
    S_PARK = 2'd2
  } state_e;

  // Cycles from a posedge pad sample to o_wide.
  localparam int unsigned CAPTURE_LAT = 2;
  // Cycles after release whose samples are still discarded.
  localparam int unsigned SETTLE = 1;

  // Width of the park counter; at least one bit even when parking is off.
  function automatic int unsigned cnt_width(input int unsigned turn_cycles);
    int unsigned w;
    w = $clog2(turn_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/xsdddr_lane.sv
// One DDR pad lane: a 2:1 output serializer and a 1:2 input deserializer.
//
// Ports:
//   clk        clock; output pair and capture pipeline on posedge
//   rst        synchronous active-high reset
//   pair_next  {high-phase bit, low-phase bit} to load on the next posedge
//   pin_out    serialized pad output (bit 1 while clk high, bit 0 while low)
//   pin_in     pad input
//   dly        capture delay in half-cycles (XSDDDR_BUS_SAMPLE_DLY_EN only)
//   wide       captured {pos-half, neg-half}, all ones when Bidir=0
//
// Macros:
//   XSDDDR_BUS_SAMPLE_DLY_EN  adds the dly port and the half-cycle delay line
//   XSDDDR_VENDOR_PRIMS       use a vendor ODDR for the output serializer
module xsdddr_lane #(
  parameter bit Bidir = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pair_next,
  output logic       pin_out,
  input  logic       pin_in,
`ifdef XSDDDR_BUS_SAMPLE_DLY_EN
  input  logic [1:0] dly,
`endif
  output logic [1:0] wide
);

`ifdef XSDDDR_VENDOR_PRIMS
  // SAME_EDGE ODDR is itself the pair register; the sync set gives all-ones reset.
  ODDR #(
    .DDR_CLK_EDGE("SAME_EDGE"),
    .INIT        (1'b1),
    .SRTYPE      ("SYNC")
  ) u_oddr (
    .Q (pin_out),
    .C (clk),
    .CE(1'b1),
    .D1(pair_next[1]),
    .D2(pair_next[0]),
    .R (1'b0),
    .S (rst)
  );
`else
  logic [1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) out_q <= 2'b11;
    else     out_q <= pair_next;
  end

  assign pin_out = clk ? out_q[1] : out_q[0];
`endif

  if (Bidir) begin : g_cap
    logic       pos_q;
    logic [1:0] stage_q;

    always_ff @(posedge clk) begin
      if (rst) pos_q <= 1'b1;
      else     pos_q <= pin_in;
    end

`ifdef XSDDDR_BUS_SAMPLE_DLY_EN
    logic [1:0] neg_q;    // [1] is the previous cycle's negedge sample
    logic [1:0] stage2_q;

    always_ff @(negedge clk) neg_q <= {neg_q[0], pin_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q  <= 2'b11;
        stage2_q <= 2'b11;
        wide     <= 2'b11;
      end else begin
        // Odd delays pair an older negedge sample with the newer posedge one.
        stage_q  <= dly[0] ? {neg_q[1], pos_q} : {pos_q, neg_q[0]};
        stage2_q <= stage_q;
        wide     <= dly[1] ? stage2_q : stage_q;
      end
    end
`else
    logic neg_q;

    always_ff @(negedge clk) neg_q <= pin_in;

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= 2'b11;
        wide    <= 2'b11;
      end else begin
        stage_q <= {pos_q, neg_q};
        wide    <= stage_q;
      end
    end
`endif
  end else begin : g_nocap
    assign wide = 2'b11;
  end

endmodule

// File: rtl/xsdddr_bus.sv
// NW-lane DDR pad front end for the SD/eMMC bus. A direction FSM owns the
// turnaround: after i_en drops the lanes are driven all-ones for TURN_CYCLES
// cycles before release, and o_wide_valid marks captures taken while the
// bus had been released long enough to settle.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_en             request to drive the bus
//   i_data           lane k pair = i_data[2k+1:2k] = {high phase, low phase}
//   o_pin            serialized pad outputs
//   io_pin_tristate  1 = pads released (same value on every lane)
//   i_pin            pad inputs
//   i_sample_dly     capture delay, half-cycles (XSDDDR_BUS_SAMPLE_DLY_EN only)
//   o_wide           captured {pos-half, neg-half} per lane
//   o_wide_valid     o_wide was sampled while the bus was released
//   o_busy           FSM is not in S_IN
//
// Macro XSDDDR_BUS_SAMPLE_DLY_EN enables the programmable capture delay.
module xsdddr_bus
  import xsdddr_pkg::*;
#(
  parameter int unsigned NW          = 4,
  parameter bit          OPT_BIDIR   = 1'b1,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic [2*NW-1:0] i_data,
  output logic [NW-1:0]   o_pin,
  output logic [NW-1:0]   io_pin_tristate,
  input  logic [NW-1:0]   i_pin,
`ifdef XSDDDR_BUS_SAMPLE_DLY_EN
  input  logic [1:0]      i_sample_dly,
`endif
  output logic [2*NW-1:0] o_wide,
  output logic            o_wide_valid,
  output logic            o_busy
);

  localparam int unsigned CntW = cnt_width(TURN_CYCLES);
`ifdef XSDDDR_BUS_SAMPLE_DLY_EN
  localparam int unsigned HistD = CAPTURE_LAT + SETTLE + 2;
`else
  localparam int unsigned HistD = CAPTURE_LAT + SETTLE;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tri_q;
  logic [HistD-1:0] tri_hist_q;  // bit i = tri_q delayed i+1 cycles
  logic [2*NW-1:0] pair_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IN: begin
        if (i_en) state_d = S_OUT;
      end
      S_OUT: begin
        if (!i_en) begin
          if (TURN_CYCLES > 0) begin
            state_d = S_PARK;
            cnt_d   = CntW'(TURN_CYCLES - 1);
          end else begin
            state_d = S_IN;
          end
        end
      end
      S_PARK: begin
        if (i_en)                state_d = S_OUT;
        else if (cnt_q == '0)    state_d = S_IN;
        else                     cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IN;
      cnt_q      <= '0;
      tri_q      <= OPT_BIDIR;
      tri_hist_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      // Keyed on the next state so release and data changes share one edge.
      tri_q      <= OPT_BIDIR && (state_d == S_IN);
      tri_hist_q <= {tri_hist_q[HistD-2:0], tri_q};
    end
  end

  assign pair_next       = (state_d == S_OUT) ? i_data : '1;
  assign io_pin_tristate = {NW{tri_q}};
  assign o_busy          = (state_q != S_IN);

`ifdef XSDDDR_BUS_SAMPLE_DLY_EN
  logic [1:0] dly_q;
  logic [2:0] hold_q;  // blanks valid while the capture path refills
  logic [2:0] idx_a, idx_b;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dly_q  <= 2'd0;
      hold_q <= 3'd0;
    end else if ((state_q == S_IN) && (i_sample_dly != dly_q)) begin
      dly_q  <= i_sample_dly;
      hold_q <= 3'd4;
    end else if (hold_q != 3'd0) begin
      hold_q <= hold_q - 3'd1;
    end
  end

  // Extra whole cycles of capture latency: ceil(dly/2).
  assign idx_a = 3'(CAPTURE_LAT - 1) + {2'b0, dly_q[1]} + {2'b0, dly_q[0]};
  assign idx_b = idx_a + 3'(SETTLE);
  assign o_wide_valid = tri_hist_q[idx_a] & tri_hist_q[idx_b] & (hold_q == 3'd0);
`else
  assign o_wide_valid = tri_hist_q[CAPTURE_LAT-1] & tri_hist_q[CAPTURE_LAT+SETTLE-1];
`endif

  for (genvar k = 0; k < NW; k++) begin : g_lane
    xsdddr_lane #(
      .Bidir(OPT_BIDIR)
    ) u_lane (
      .clk      (i_clk),
      .rst      (i_reset),
      .pair_next(pair_next[2*k+1:2*k]),
      .pin_out  (o_pin[k]),
      .pin_in   (i_pin[k]),
`ifdef XSDDDR_BUS_SAMPLE_DLY_EN
      .dly      (dly_q),
`endif
      .wide     (o_wide[2*k+1:2*k])
    );
  end

endmodule
